// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : round_sequencer
// Brief    : Round/turn sequencer for the Black-and-White card game; checks and
//            commits card selections, tracks the leader, strobes the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module round_sequencer #(
  parameter int NCARD = 9,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_confirm,
  input  logic             btn_next,
  input  logic             btn_abort,
  input  logic [NCARD-1:0] sw,
  input  logic [1:0]       matchresult,
  input  logic             finish,
  output logic [2:0]       phase,
  output logic             active_player,
  output logic             leader,
  output logic [NCARD-1:0] p1_card,
  output logic [NCARD-1:0] p2_card,
  output logic [IDXW-1:0]  p1_handcard,
  output logic [IDXW-1:0]  p2_handcard,
  output logic             p1_hand_valid,
  output logic             p2_hand_valid,
  output logic             score_pulse,
  output logic             sel_error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_LEAD   = 3'b001,
    ST_FOLLOW = 3'b010,
    ST_JUDGE  = 3'b011,
    ST_SHOW   = 3'b100,
    ST_DONE   = 3'b101
  } state_t;

  localparam logic [NCARD-1:0] C_FULL_MASK = '1;

  state_t           state_q, state_d;
  logic [NCARD-1:0] p1_mask_q, p1_mask_d, p2_mask_q, p2_mask_d;
  logic [IDXW-1:0]  p1_hand_q, p1_hand_d, p2_hand_q, p2_hand_d;
  logic             p1_hv_q, p1_hv_d, p2_hv_q, p2_hv_d;
  logic             leader_q, leader_d;
  logic             active_q, active_d;
  logic             score_q, score_d;
  logic             selerr_q, selerr_d;

  logic             w_onehot;
  logic [IDXW-1:0]  w_idx;
  logic             w_mover;
  logic [NCARD-1:0] w_active_mask;
  logic             w_valid;

  // Selection decode: one-hot test and binary index of the selected card.
  always_comb begin
    w_onehot = (sw != '0) && ((sw & (sw - NCARD'(1))) == '0);
    w_idx    = '0;
    for (int k = 0; k < NCARD; k++) begin
      if (sw[k]) w_idx = IDXW'(k);
    end
    w_mover       = (state_q == ST_FOLLOW) ? ~leader_q : leader_q;
    w_active_mask = w_mover ? p2_mask_q : p1_mask_q;
    w_valid       = w_onehot && ((sw & w_active_mask) != '0);
  end

  always_comb begin
    state_d   = state_q;
    p1_mask_d = p1_mask_q;
    p2_mask_d = p2_mask_q;
    p1_hand_d = p1_hand_q;
    p2_hand_d = p2_hand_q;
    p1_hv_d   = p1_hv_q;
    p2_hv_d   = p2_hv_q;
    leader_d  = leader_q;
    selerr_d  = 1'b0;

    if (btn_abort) begin
      state_d   = ST_IDLE;
      p1_mask_d = C_FULL_MASK;
      p2_mask_d = C_FULL_MASK;
      p1_hand_d = '0;
      p2_hand_d = '0;
      p1_hv_d   = 1'b0;
      p2_hv_d   = 1'b0;
      leader_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_confirm) begin
            state_d   = ST_LEAD;
            p1_mask_d = C_FULL_MASK;
            p2_mask_d = C_FULL_MASK;
            p1_hand_d = '0;
            p2_hand_d = '0;
            p1_hv_d   = 1'b0;
            p2_hv_d   = 1'b0;
            leader_d  = 1'b0;
          end
        end
        ST_LEAD, ST_FOLLOW: begin
          if (btn_confirm) begin
            if (w_valid) begin
              if (w_mover) begin
                p2_mask_d = p2_mask_q & ~sw;
                p2_hand_d = w_idx;
                p2_hv_d   = 1'b1;
              end else begin
                p1_mask_d = p1_mask_q & ~sw;
                p1_hand_d = w_idx;
                p1_hv_d   = 1'b1;
              end
              state_d = (state_q == ST_LEAD) ? ST_FOLLOW : ST_JUDGE;
            end else begin
              selerr_d = 1'b1;
            end
          end
        end
        ST_JUDGE: begin
          case (matchresult)
            2'b01:   leader_d = 1'b0;
            2'b10:   leader_d = 1'b1;
            default: leader_d = leader_q;
          endcase
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (btn_next) begin
            if (finish || ((p1_mask_q == '0) && (p2_mask_q == '0))) begin
              state_d = ST_DONE;
            end else begin
              p1_hand_d = '0;
              p2_hand_d = '0;
              p1_hv_d   = 1'b0;
              p2_hv_d   = 1'b0;
              state_d   = ST_LEAD;
            end
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Registered outputs follow the state being entered.
    score_d = (state_d == ST_JUDGE);
    case (state_d)
      ST_LEAD:   active_d = leader_d;
      ST_FOLLOW: active_d = ~leader_d;
      default:   active_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      p1_mask_q <= C_FULL_MASK;
      p2_mask_q <= C_FULL_MASK;
      p1_hand_q <= '0;
      p2_hand_q <= '0;
      p1_hv_q   <= 1'b0;
      p2_hv_q   <= 1'b0;
      leader_q  <= 1'b0;
      active_q  <= 1'b0;
      score_q   <= 1'b0;
      selerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1_mask_q <= p1_mask_d;
      p2_mask_q <= p2_mask_d;
      p1_hand_q <= p1_hand_d;
      p2_hand_q <= p2_hand_d;
      p1_hv_q   <= p1_hv_d;
      p2_hv_q   <= p2_hv_d;
      leader_q  <= leader_d;
      active_q  <= active_d;
      score_q   <= score_d;
      selerr_q  <= selerr_d;
    end
  end

  assign phase         = state_q;
  assign active_player = active_q;
  assign leader        = leader_q;
  assign p1_card       = p1_mask_q;
  assign p2_card       = p2_mask_q;
  assign p1_handcard   = p1_hand_q;
  assign p2_handcard   = p2_hand_q;
  assign p1_hand_valid = p1_hv_q;
  assign p2_hand_valid = p2_hv_q;
  assign score_pulse   = score_q;
  assign sel_error     = selerr_q;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_sequencer
// Brief    : Directed + randomized self-checking bench for round_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

  localparam int NCARD = 9;
  localparam int IDXW  = 4;

  logic             clk;
  logic             reset;
  logic             btn_confirm, btn_next, btn_abort;
  logic [NCARD-1:0] sw;
  logic [1:0]       matchresult;
  logic             finish;
  logic [2:0]       phase;
  logic             active_player, leader;
  logic [NCARD-1:0] p1_card, p2_card;
  logic [IDXW-1:0]  p1_handcard, p2_handcard;
  logic             p1_hand_valid, p2_hand_valid;
  logic             score_pulse, sel_error;

  int n_checks = 0;
  int n_errors = 0;

  round_sequencer #(.NCARD(NCARD), .IDXW(IDXW)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .btn_confirm   (btn_confirm),
    .btn_next      (btn_next),
    .btn_abort     (btn_abort),
    .sw            (sw),
    .matchresult   (matchresult),
    .finish        (finish),
    .phase         (phase),
    .active_player (active_player),
    .leader        (leader),
    .p1_card       (p1_card),
    .p2_card       (p2_card),
    .p1_handcard   (p1_handcard),
    .p2_handcard   (p2_handcard),
    .p1_hand_valid (p1_hand_valid),
    .p2_hand_valid (p2_hand_valid),
    .score_pulse   (score_pulse),
    .sel_error     (sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: game rules on card-availability arrays and a phase number.
  int m_phase;
  bit avail [2][NCARD];
  int m_hand [2];
  bit m_hv [2];
  bit m_leader, m_score, m_err;

  function automatic void model_reset();
    m_phase = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NCARD; k++) avail[p][k] = 1'b1;
      m_hand[p] = 0;
      m_hv[p]   = 1'b0;
    end
    m_leader = 1'b0;
  endfunction

  function automatic logic [NCARD-1:0] mask_of(input int p);
    logic [NCARD-1:0] m;
    m = '0;
    for (int k = 0; k < NCARD; k++) m[k] = avail[p][k];
    return m;
  endfunction

  function automatic int cards_left();
    int n;
    n = 0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NCARD; k++) n += int'(avail[p][k]);
    return n;
  endfunction

  function automatic void model_update(input logic r, c, n, a,
                                       input logic [NCARD-1:0] s,
                                       input logic [1:0] mr, input logic f);
    int pl, cnt, idx;
    m_err = 1'b0;
    if (r || a) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (c) begin model_reset(); m_phase = 1; end
        1, 2: if (c) begin
          pl  = (m_phase == 1) ? int'(m_leader) : int'(!m_leader);
          cnt = 0;
          idx = 0;
          for (int k = 0; k < NCARD; k++) if (s[k]) begin cnt++; idx = k; end
          if (cnt == 1 && avail[pl][idx]) begin
            avail[pl][idx] = 1'b0;
            m_hand[pl] = idx;
            m_hv[pl]   = 1'b1;
            m_phase++;
          end else begin
            m_err = 1'b1;
          end
        end
        3: begin
          if (mr == 2'b01) m_leader = 1'b0;
          else if (mr == 2'b10) m_leader = 1'b1;
          m_phase = 4;
        end
        4: if (n) begin
          if (f || cards_left() == 0) m_phase = 5;
          else begin
            m_hand[0] = 0; m_hand[1] = 0;
            m_hv[0] = 1'b0; m_hv[1] = 1'b0;
            m_phase = 1;
          end
        end
        default: ;
      endcase
    end
    m_score = (m_phase == 3);
  endfunction

  function automatic bit exp_active();
    if (m_phase == 1) return m_leader;
    if (m_phase == 2) return !m_leader;
    return 1'b0;
  endfunction

  task automatic compare_all();
    check("phase",    32'(phase),         32'(m_phase));
    check("active",   32'(active_player), 32'(exp_active()));
    check("leader",   32'(leader),        32'(m_leader));
    check("p1_card",  32'(p1_card),       32'(mask_of(0)));
    check("p2_card",  32'(p2_card),       32'(mask_of(1)));
    check("p1_hand",  32'(p1_handcard),   32'(m_hand[0]));
    check("p2_hand",  32'(p2_handcard),   32'(m_hand[1]));
    check("p1_valid", 32'(p1_hand_valid), 32'(m_hv[0]));
    check("p2_valid", 32'(p2_hand_valid), 32'(m_hv[1]));
    check("score",    32'(score_pulse),   32'(m_score));
    check("sel_err",  32'(sel_error),     32'(m_err));
  endtask

  task automatic step(input logic r, c, n, a, input logic [NCARD-1:0] s,
                      input logic [1:0] mr, input logic f);
    reset = r; btn_confirm = c; btn_next = n; btn_abort = a;
    sw = s; matchresult = mr; finish = f;
    model_update(r, c, n, a, s, mr, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [1:0] mr);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, mr, 1'b0);
  endtask
  task automatic confirm(input logic [NCARD-1:0] s);
    step(1'b0, 1'b1, 1'b0, 1'b0, s, 2'b00, 1'b0);
  endtask
  task automatic next(input logic f);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 2'b00, f);
  endtask
  task automatic abort_();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, 2'b00, 1'b0);
  endtask

  logic r_r, r_c, r_n, r_a, r_f;
  logic [NCARD-1:0] r_s;
  logic [1:0] r_mr;

  initial begin
    model_reset();
    // Reset and start
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
    check("x_rst_phase", 32'(phase), 32'd0);
    check("x_rst_mask",  32'(p1_card), 32'h1FF);
    confirm('0);
    check("x_start_phase", 32'(phase), 32'd1);
    check("x_start_act",   32'(active_player), 32'd0);
    // Invalid multi-bit selection in LEAD
    confirm(9'h011);
    check("x_multi_err",  32'(sel_error), 32'd1);
    check("x_multi_mask", 32'(p1_card), 32'h1FF);
    idle(2'b00);
    check("x_err_once", 32'(sel_error), 32'd0);
    // Full round 1
    confirm(9'h010);
    check("x_r1_p1card", 32'(p1_card), 32'h1EF);
    check("x_r1_p1hand", 32'(p1_handcard), 32'd4);
    check("x_r1_act",    32'(active_player), 32'd1);
    confirm(9'h004);
    check("x_r1_p2card", 32'(p2_card), 32'h1FB);
    check("x_r1_p2hand", 32'(p2_handcard), 32'd2);
    check("x_r1_judge",  32'(phase), 32'd3);
    check("x_r1_score",  32'(score_pulse), 32'd1);
    idle(2'b01);
    check("x_r1_show",   32'(phase), 32'd4);
    check("x_r1_score0", 32'(score_pulse), 32'd0);
    check("x_r1_leader", 32'(leader), 32'd0);
    next(1'b0);
    // Round 2: reused card and empty selection, then p2 wins
    confirm(9'h010);
    check("x_reuse_err", 32'(sel_error), 32'd1);
    idle(2'b00);
    confirm(9'h000);
    check("x_zero_err", 32'(sel_error), 32'd1);
    confirm(9'h001);
    confirm(9'h001);
    idle(2'b10);
    next(1'b0);
    check("x_swap_phase", 32'(phase), 32'd1);
    check("x_swap_act",   32'(active_player), 32'd1);
    // Round 3: draw keeps leader, then finish
    confirm(9'h002);
    confirm(9'h002);
    idle(2'b11);
    check("x_draw_leader", 32'(leader), 32'd1);
    next(1'b1);
    check("x_done", 32'(phase), 32'd5);
    confirm(9'h100);
    idle(2'b00);
    next(1'b0);
    check("x_done_hold", 32'(phase), 32'd5);
    // Nine draw rounds exhaust both hands
    abort_();
    confirm('0);
    for (int k = 0; k < NCARD; k++) begin
      confirm(NCARD'(1) << k);
      confirm(NCARD'(1) << k);
      idle(2'b11);
      next(1'b0);
    end
    check("x_exhaust_done", 32'(phase), 32'd5);
    // Abort beats confirm in FOLLOW
    abort_();
    confirm('0);
    confirm(9'h080);
    step(1'b0, 1'b1, 1'b0, 1'b1, 9'h080, 2'b00, 1'b0);
    check("x_abort_phase", 32'(phase), 32'd0);
    check("x_abort_mask",  32'(p1_card), 32'h1FF);
    check("x_abort_score", 32'(score_pulse), 32'd0);
    // Reset while in JUDGE
    confirm('0);
    confirm(9'h020);
    confirm(9'h020);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 2'b10, 1'b0);
    check("x_rstj_score", 32'(score_pulse), 32'd0);
    check("x_rstj_phase", 32'(phase), 32'd0);

    // Randomized: one busy cycle with random pulses, one quiet cycle
    for (int i = 0; i < 1500; i++) begin
      r_r = ($urandom_range(0, 199) == 0);
      r_a = ($urandom_range(0, 59) == 0);
      r_c = ($urandom_range(0, 1) == 0);
      r_n = ($urandom_range(0, 2) == 0);
      r_f = ($urandom_range(0, 9) == 0);
      r_mr = 2'($urandom);
      if ($urandom_range(0, 9) < 8) r_s = NCARD'(1) << $urandom_range(0, NCARD - 1);
      else r_s = NCARD'($urandom);
      step(r_r, r_c, r_n, r_a, r_s, r_mr, r_f);
      step(1'b0, 1'b0, 1'b0, 1'b0, r_s, 2'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
